i2s_sample_rx: RTL and testbench

Upstream source stage for the filter state machine. It receives a standard I2S serial stream from the external codec (BCLK, WS, SD), which is asynchronous to clk_i, and oversamples it in the clk_i domain. It deserialises each channel word into a signed 16-bit sample and presents it with a one-cycle valid strobe on data_i of the filter stage. It has an enable so the codec path can be silenced together with the filter OFF mode.

---
 rtl/filter_pkg.sv | 11 +
 rtl/async_edge_sync.sv | 28 ++
 rtl/i2s_sample_rx.sv | 107 ++++++++++
 tb/tb_i2s_sample_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// filter_pkg: sample width and channel encoding shared between the I2S receiver and the filter state machine.
package filter_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/async_edge_sync.sv
// async_edge_sync: multi-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module async_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~prev_q;

endmodule

// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: oversampling I2S receiver delivering left-justified signed samples with a valid strobe.
module i2s_sample_rx
    import filter_pkg::*;
#(
    parameter int DATA_W      = SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     bclk_i,
    input  logic                     ws_i,
    input  logic                     sd_i,
    output logic signed [DATA_W-1:0] sample_o,
    output logic                     chan_o,
    output logic                     valid_o,
    output logic                     err_o
);

    localparam int            CW   = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_W);

    logic bclk_rise, ws_s, sd_s, unused_bclk_s, unused_ws_rise, unused_sd_rise;

    async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(bclk_i), .q_o(unused_bclk_s), .rise_o(bclk_rise)
    );
    async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ws (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ws_i), .q_o(ws_s), .rise_o(unused_ws_rise)
    );
    async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sd (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(sd_i), .q_o(sd_s), .rise_o(unused_sd_rise)
    );

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, sample_q, sample_d;
    logic              armed_q, armed_d, ws_prev_q, ws_prev_d, done_q, done_d;
    logic              valid_q, valid_d, err_q, err_d;
    chan_e             word_ch_q, word_ch_d, chan_q, chan_d;

    // A boundary edge only flags done; the word is emitted on the following cycle.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        ws_prev_d = ws_prev_q;
        word_ch_d = word_ch_q;
        sample_d  = sample_q;
        chan_d    = chan_q;
        done_d    = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (done_q) begin
            if (armed_q) begin
                sample_d = shift_q << (FULL - cnt_q);
                chan_d   = word_ch_q;
                valid_d  = 1'b1;
                err_d    = cnt_q < FULL;
            end
            cnt_d   = '0;
            shift_d = '0;
            armed_d = 1'b1;
        end else if (bclk_rise) begin
            if (cnt_q < FULL) begin
                shift_d = {shift_q[DATA_W-2:0], sd_s};
                cnt_d   = cnt_q + 1'b1;
            end
            if (ws_s != ws_prev_q) begin
                done_d    = 1'b1;
                word_ch_d = chan_e'(ws_prev_q);
                ws_prev_d = ws_s;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
            ws_prev_q <= 1'b0;
            word_ch_q <= LEFT;
            done_q    <= 1'b0;
            sample_q  <= '0;
            chan_q    <= LEFT;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            ws_prev_q <= ws_prev_d;
            word_ch_q <= word_ch_d;
            done_q    <= done_d;
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign sample_o = sample_q;
    assign chan_o   = chan_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb_i2s_sample_rx: drives I2S word streams and checks emitted samples against a word-level scoreboard.
module tb_i2s_sample_rx;

    logic        clk = 0, rst = 1, en = 0, bclk = 0, ws = 0, sd = 0;
    logic [15:0] sample_o;
    logic        chan_o, valid_o, err_o;
    int          cyc = 0, checks = 0, errors = 0, half = 4;

    typedef struct {
        logic [15:0] s;
        logic        ch;
        logic        e;
        int          t;
    } exp_t;
    exp_t q[$];

    i2s_sample_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bclk_i(bclk), .ws_i(ws), .sd_i(sd),
        .sample_o(sample_o), .chan_o(chan_o), .valid_o(valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t x;
        if (valid_o || err_o) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe valid=%0d err=%0d sample=%h chan=%0d", valid_o, err_o, sample_o, chan_o);
            end else begin
                x = q.pop_front();
                checks += 4;
                if (valid_o !== 1'b1) begin errors++; $display("FAIL valid got %b want 1", valid_o); end
                if (sample_o !== x.s) begin errors++; $display("FAIL sample got %h want %h", sample_o, x.s); end
                if ({chan_o, err_o} !== {x.ch, x.e}) begin errors++; $display("FAIL chan_err got %b%b want %b%b", chan_o, err_o, x.ch, x.e); end
                if (cyc !== x.t) begin errors++; $display("FAIL latency got cycle %0d want %0d", cyc, x.t); end
            end
        end
    end

    task automatic send_slot(input logic w, input logic d, output int t);
        @(negedge clk);
        bclk = 0; ws = w; sd = d;
        repeat (half) @(negedge clk);
        bclk = 1;
        t = cyc;
        repeat (half - 1) @(negedge clk);
    endtask

    // A word of n bits MSB first; WS flips on its last slot (I2S one-bit delay).
    task automatic send_word(input logic ch, input logic [31:0] v, input int n, input bit emit);
        int   t;
        exp_t x;
        for (int j = 0; j < n; j++) send_slot(j == n - 1 ? ~ch : ch, v[n-1-j], t);
        if (emit) begin
            x.s  = n >= 16 ? 16'(v >> (n - 16)) : 16'(v << (16 - n));
            x.ch = ch;
            x.e  = n < 16;
            x.t  = t + 4;
            q.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bclk = 0; rst = 1; en = 1;
        repeat (4) @(negedge clk);
        rst = 0;
    endtask

    task automatic idle_check(input string name);
        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL %s missing %0d samples", name, q.size()); q.delete(); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sample_o, chan_o, valid_o, err_o} !== 19'd0) begin
            errors++; $display("FAIL reset_state got %h/%b/%b/%b want 0", sample_o, chan_o, valid_o, err_o);
        end
    endtask

    task automatic test_frames();
        do_reset(); half = 4;
        for (int k = 0; k < 6; k++) send_word(k[0], k[0] ? 32'h7FFE_0000 : 32'h8001_0000, 32, k > 0);
        idle_check("frames");
    endtask

    task automatic test_short();
        do_reset(); half = 3;
        for (int k = 0; k < 4; k++) send_word(k[0], k[0] ? 32'h123 : 32'hABC, 12, k > 0);
        idle_check("short");
    endtask

    task automatic test_long();
        do_reset(); half = 3;
        for (int k = 0; k < 4; k++) send_word(k[0], k[0] ? 32'($urandom_range(0, 24'hFFFFFF)) : 32'h123456, 24, k > 0);
        idle_check("long");
    endtask

    task automatic test_enable();
        int t;
        do_reset(); half = 3;
        send_word(0, 32'h1111, 16, 0);
        send_word(1, 32'h2222, 16, 1);
        send_word(0, 32'h3333, 16, 1);
        for (int j = 0; j < 8; j++) send_slot(1, $urandom_range(0, 1), t);
        @(negedge clk);
        bclk = 0; en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sample_o !== 16'd0) begin errors++; $display("FAIL enable_low_sample got %h want 0000", sample_o); end
        end
        en = 1;
        send_word(0, 32'h4444, 16, 0);
        send_word(1, 32'($urandom_range(0, 16'hFFFF)), 16, 1);
        send_word(0, 32'($urandom_range(0, 16'hFFFF)), 16, 1);
        send_word(1, 32'h5A5A, 16, 1);
        idle_check("enable");
    endtask

    task automatic test_rst_boundary();
        int t;
        do_reset(); half = 4;
        send_word(0, 32'h1234, 16, 0);
        send_word(1, 32'h7FFE, 16, 1);
        for (int j = 0; j < 15; j++) send_slot(0, 1'b1, t);
        @(negedge clk);
        bclk = 0; ws = 1; sd = 1;
        repeat (4) @(negedge clk);
        bclk = 1;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({sample_o, chan_o, valid_o, err_o} !== 19'd0) begin
                errors++; $display("FAIL rst_boundary cycle %0d got %h/%b/%b/%b want 0", i, sample_o, chan_o, valid_o, err_o);
            end
            @(negedge clk);
        end
        bclk = 0;
        idle_check("rst_boundary");
    endtask

    task automatic test_back_to_back();
        do_reset(); half = 2;
        for (int k = 0; k < 41; k++) send_word(k[0], 32'($urandom_range(0, 16'hFFFF)), 16, k > 0);
        idle_check("back_to_back");
    endtask

    initial begin
        test_reset();
        test_frames();
        test_short();
        test_long();
        test_enable();
        test_rst_boundary();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
